// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO used as a rate/burst buffer
// between a producer and a consumer sharing one clock. Provides an occupancy
// count, programmable almost-full/almost-empty thresholds, a registered read
// port with a one-cycle valid strobe, and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     clr_err,
  input  logic                     write,
  input  logic [WIDTH-1:0]         iData,
  input  logic                     read,
  output logic [WIDTH-1:0]         oData,
  output logic                     valid_o,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  // Pointer width addresses the array; the count needs one extra bit so
  // that a completely full FIFO (DEPTH) is distinguishable from empty (0).
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Storage array; deliberately not reset so it can map onto RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] oData_q, oData_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic fullInt;
  logic emptyInt;
  logic wrAcc;
  logic rdAcc;
  logic ovfEvent;
  logic unfEvent;

  // Status flags are decoded straight from the registered count so they move
  // on the same edge as the count itself.
  always_comb begin
    fullInt      = (count_q == DEPTH_C);
    emptyInt     = (count_q == '0);
    full         = fullInt;
    empty        = emptyInt;
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    count        = count_q;
    oData        = oData_q;
    valid_o      = valid_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

  // Acceptance: a write into a full FIFO is still taken when a read frees a
  // slot in the same cycle; a read of an empty FIFO never falls through to
  // the word being written in that cycle.
  always_comb begin
    wrAcc    = write & (~fullInt | read);
    rdAcc    = read & ~emptyInt;
    ovfEvent = write & fullInt & ~read;
    unfEvent = read & emptyInt;
  end

  // Next-state for pointers, occupancy, read port and sticky error flags.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    oData_d     = oData_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wrAcc) begin
      wptr_d = wptr_q + AW'(1);
    end

    if (rdAcc) begin
      rptr_d  = rptr_q + AW'(1);
      oData_d = mem_q[rptr_q];
      valid_d = 1'b1;
    end

    case ({wrAcc, rdAcc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clearing is overridden by an error occurring in the same cycle.
    overflow_d  = (overflow_q & ~clr_err) | ovfEvent;
    underflow_d = (underflow_q & ~clr_err) | unfEvent;
  end

  // Control and read-port registers, asynchronously returned to idle by RSTn.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      oData_q     <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      oData_q     <= oData_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Array write port; a write and a read of the same slot in one cycle
  // returns the old contents because the read samples before this update.
  always_ff @(posedge CLK) begin
    if (wrAcc) begin
      mem_q[wptr_q] <= iData;
    end
  end

endmodule
